dequant_loader: RTL and testbench

- Reverse path of the output quantizer.
- Reads saturated 16-bit results back from the output SRAM, one 32-bit word per cycle.
- Unpacks and sign-extends each lane to accumulator width (2*DATA_WIDTH+5).
- Presents full ARRAY_SIZE-lane vectors on a valid/ready port. The systolic array uses these to reload partial sums or to chain layers.

---
 rtl/dequant_loader_pkg.sv | 36 +++
 rtl/dequant_loader_lane_unpack.sv | 36 +++
 rtl/dequant_loader.sv | 195 +++++++++++++++++++
 tb/tb_dequant_loader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dequant_loader_pkg.sv
// rtl/dequant_loader_pkg.sv - shared constants, FSM encoding and lane sign-extension for dequant_loader
//
// Purpose: default geometry of the dequant loader and the quantity derivations
// used by it (accumulator width, lanes per SRAM word, words per vector), the
// FSM state encoding, and a reusable 16-bit -> accumulator-width sign extender.
// Ports: none (package).
package dequant_loader_pkg;

  localparam int DEF_ARRAY_SIZE        = 32;
  localparam int DEF_SRAM_DATA_WIDTH   = 32;
  localparam int DEF_DATA_WIDTH        = 8;
  localparam int DEF_OUTPUT_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH        = 10;
  localparam int DEF_VEC_CNT_WIDTH     = 8;

  // Accumulator width of the systolic array: product width plus guard bits.
  localparam int ORI_WIDTH      = 2 * DEF_DATA_WIDTH + 5;
  localparam int LANES_PER_WORD = DEF_SRAM_DATA_WIDTH / DEF_OUTPUT_DATA_WIDTH;
  localparam int WORDS_PER_VEC  = DEF_ARRAY_SIZE / LANES_PER_WORD;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  // Stored lanes are already saturated, so widening is a pure sign extension.
  function automatic logic [ORI_WIDTH-1:0] sign_extend_lane(
    input logic [DEF_OUTPUT_DATA_WIDTH-1:0] v
  );
    return {{(ORI_WIDTH - DEF_OUTPUT_DATA_WIDTH){v[DEF_OUTPUT_DATA_WIDTH-1]}}, v};
  endfunction

endpackage

// File: rtl/dequant_loader_lane_unpack.sv
// rtl/dequant_loader_lane_unpack.sv - splits one SRAM word into sign-extended lanes with target lane indices
//
// Purpose: combinational unpack of one SRAM word. Lane j of the word sits in
// bits [j*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH] and belongs to vector lane
// LANES_PER_WORD*word_idx + j.
// Ports:
//   word_i      SRAM word
//   word_idx_i  index of that word within its vector
//   lanes_o     LANES_PER_WORD sign-extended lanes, lane j at [j*ORI_WIDTH +: ORI_WIDTH]
//   lane_idx_o  destination lane index of each, j at [j*LANE_IDX_WIDTH +: LANE_IDX_WIDTH]
module lane_unpack
  import dequant_loader_pkg::*;
#(
  parameter int SRAM_DATA_WIDTH   = DEF_SRAM_DATA_WIDTH,
  parameter int OUTPUT_DATA_WIDTH = DEF_OUTPUT_DATA_WIDTH,
  parameter int ORI_W             = ORI_WIDTH,
  parameter int WORD_IDX_WIDTH    = 4,
  parameter int LANE_IDX_WIDTH    = 5
) (
  input  logic [SRAM_DATA_WIDTH-1:0]                                      word_i,
  input  logic [WORD_IDX_WIDTH-1:0]                                       word_idx_i,
  output logic [(SRAM_DATA_WIDTH/OUTPUT_DATA_WIDTH)*ORI_W-1:0]            lanes_o,
  output logic [(SRAM_DATA_WIDTH/OUTPUT_DATA_WIDTH)*LANE_IDX_WIDTH-1:0]   lane_idx_o
);

  localparam int LPW = SRAM_DATA_WIDTH / OUTPUT_DATA_WIDTH;

  for (genvar j = 0; j < LPW; j++) begin : g_lane
    assign lanes_o[j*ORI_W +: ORI_W] =
      {{(ORI_W - OUTPUT_DATA_WIDTH){word_i[j*OUTPUT_DATA_WIDTH + OUTPUT_DATA_WIDTH - 1]}},
       word_i[j*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH]};
    assign lane_idx_o[j*LANE_IDX_WIDTH +: LANE_IDX_WIDTH] =
      LANE_IDX_WIDTH'(word_idx_i * LPW + j);
  end

endmodule

// File: rtl/dequant_loader.sv
// rtl/dequant_loader.sv - reloads quantized results from SRAM as full-width signed lane vectors
//
// Purpose: reads WORDS_PER_VEC SRAM words per vector, sign-extends each 16-bit
// lane to accumulator width and presents the whole vector on a valid/ready port.
// Ports:
//   clk, srstn             clock, asynchronous active-low reset
//   start                  one-cycle request, honoured only when idle
//   base_addr, num_vec     first word address / vectors to load, latched on start
//   sram_ren, sram_raddr   SRAM read request (data returns one cycle later)
//   sram_rdata             SRAM read data
//   vec_data, vec_valid    assembled vector, lane i at [i*ORI_WIDTH +: ORI_WIDTH]
//   vec_ready              consumer accept
//   busy, done             activity flag, one-cycle completion pulse
module dequant_loader
  import dequant_loader_pkg::*;
#(
  parameter int ARRAY_SIZE        = DEF_ARRAY_SIZE,
  parameter int SRAM_DATA_WIDTH   = DEF_SRAM_DATA_WIDTH,
  parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int OUTPUT_DATA_WIDTH = DEF_OUTPUT_DATA_WIDTH,
  parameter int ADDR_WIDTH        = DEF_ADDR_WIDTH,
  parameter int VEC_CNT_WIDTH     = DEF_VEC_CNT_WIDTH,
  localparam int ORI_W            = 2 * DATA_WIDTH + 5
) (
  input  logic                        clk,
  input  logic                        srstn,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       base_addr,
  input  logic [VEC_CNT_WIDTH-1:0]    num_vec,
  output logic                        sram_ren,
  output logic [ADDR_WIDTH-1:0]       sram_raddr,
  input  logic [SRAM_DATA_WIDTH-1:0]  sram_rdata,
  output logic [ARRAY_SIZE*ORI_W-1:0] vec_data,
  output logic                        vec_valid,
  input  logic                        vec_ready,
  output logic                        busy,
  output logic                        done
);

  localparam int LPW    = SRAM_DATA_WIDTH / OUTPUT_DATA_WIDTH;
  localparam int WPV    = ARRAY_SIZE / LPW;
  localparam int WIDX_W = $clog2(WPV);
  localparam int LIDX_W = $clog2(ARRAY_SIZE);

  state_e                    state_q;
  logic [ADDR_WIDTH-1:0]     base_q;
  logic [VEC_CNT_WIDTH-1:0]  num_vec_q;
  logic [VEC_CNT_WIDTH-1:0]  vec_cnt_q;
  logic [WIDX_W-1:0]         word_cnt_q;
  logic                      ren_q;
  logic [ADDR_WIDTH-1:0]     raddr_q;
  logic                      vec_valid_q;
  logic                      busy_q;
  logic                      done_q;

  // Word issued last cycle; its data is on sram_rdata this cycle.
  logic                      cap_valid_q;
  logic [WIDX_W-1:0]         cap_idx_q;
  logic [ORI_W-1:0]          lanes_q [ARRAY_SIZE];

  logic [LPW*ORI_W-1:0]      unpacked_d;
  logic [LPW*LIDX_W-1:0]     lane_idx_d;
  logic [VEC_CNT_WIDTH-1:0]  vec_cnt_inc_d;
  logic                      last_vec_d;
  logic                      last_word_d;

  assign vec_cnt_inc_d = VEC_CNT_WIDTH'(vec_cnt_q + 1'b1);
  assign last_vec_d    = (vec_cnt_inc_d == num_vec_q);
  assign last_word_d   = (word_cnt_q == WIDX_W'(WPV - 1));

  // Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is intentional.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(
    input logic [ADDR_WIDTH-1:0]    b,
    input logic [VEC_CNT_WIDTH-1:0] v,
    input logic [WIDX_W-1:0]        w
  );
    return b + ADDR_WIDTH'(v) * ADDR_WIDTH'(WPV) + ADDR_WIDTH'(w);
  endfunction

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      num_vec_q   <= '0;
      vec_cnt_q   <= '0;
      word_cnt_q  <= '0;
      ren_q       <= 1'b0;
      raddr_q     <= '0;
      vec_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // busy_q is still set during the done cycle, which blocks a
          // back-to-back start until busy has actually fallen.
          done_q <= 1'b0;
          busy_q <= 1'b0;
          ren_q  <= 1'b0;
          if (start && !busy_q) begin
            base_q     <= base_addr;
            num_vec_q  <= num_vec;
            vec_cnt_q  <= '0;
            word_cnt_q <= '0;
            busy_q     <= 1'b1;
            if (num_vec == '0) begin
              state_q <= ST_FIN;
            end else begin
              state_q <= ST_FETCH;
              ren_q   <= 1'b1;
              raddr_q <= base_addr;
            end
          end
        end
        ST_FETCH: begin
          if (last_word_d) begin
            ren_q   <= 1'b0;
            state_q <= ST_DRAIN;
          end else begin
            word_cnt_q <= WIDX_W'(word_cnt_q + 1'b1);
            raddr_q    <= word_addr(base_q, vec_cnt_q, WIDX_W'(word_cnt_q + 1'b1));
          end
        end
        ST_DRAIN: begin
          // Last word lands in the lane bank on this edge.
          vec_valid_q <= 1'b1;
          state_q     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (vec_ready) begin
            vec_valid_q <= 1'b0;
            if (last_vec_d) begin
              state_q <= ST_FIN;
            end else begin
              vec_cnt_q  <= vec_cnt_inc_d;
              word_cnt_q <= '0;
              ren_q      <= 1'b1;
              raddr_q    <= word_addr(base_q, vec_cnt_inc_d, '0);
              state_q    <= ST_FETCH;
            end
          end
        end
        ST_FIN: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  lane_unpack #(
    .SRAM_DATA_WIDTH  (SRAM_DATA_WIDTH),
    .OUTPUT_DATA_WIDTH(OUTPUT_DATA_WIDTH),
    .ORI_W            (ORI_W),
    .WORD_IDX_WIDTH   (WIDX_W),
    .LANE_IDX_WIDTH   (LIDX_W)
  ) u_lane_unpack (
    .word_i    (sram_rdata),
    .word_idx_i(cap_idx_q),
    .lanes_o   (unpacked_d),
    .lane_idx_o(lane_idx_d)
  );

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      cap_valid_q <= 1'b0;
      cap_idx_q   <= '0;
      for (int i = 0; i < ARRAY_SIZE; i++) begin
        lanes_q[i] <= '0;
      end
    end else begin
      cap_valid_q <= ren_q;
      cap_idx_q   <= word_cnt_q;
      if (cap_valid_q) begin
        for (int j = 0; j < LPW; j++) begin
          lanes_q[lane_idx_d[j*LIDX_W +: LIDX_W]] <= unpacked_d[j*ORI_W +: ORI_W];
        end
      end
    end
  end

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_vec
    assign vec_data[i*ORI_W +: ORI_W] = lanes_q[i];
  end

  assign sram_ren   = ren_q;
  assign sram_raddr = raddr_q;
  assign vec_valid  = vec_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_dequant_loader.sv
// tb/tb_dequant_loader.sv - self-checking bench for dequant_loader
module tb_dequant_loader;

  localparam int NL = 32;
  localparam int OW = 21;
  localparam int VW = NL * OW;

  localparam int P_IDLE = 0, P_LOAD = 1, P_HOLD = 2, P_FINW = 3, P_DONE = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [9:0]    base_addr = '0;
  logic [7:0]    num_vec = '0;
  logic          sram_ren;
  logic [9:0]    sram_raddr;
  logic [31:0]   sram_rdata = '0;
  logic [VW-1:0] vec_data;
  logic          vec_valid;
  logic          vec_ready = 1'b0;
  logic          busy;
  logic          done;

  dequant_loader dut (
    .clk       (clk),
    .srstn     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .num_vec   (num_vec),
    .sram_ren  (sram_ren),
    .sram_raddr(sram_raddr),
    .sram_rdata(sram_rdata),
    .vec_data  (vec_data),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [1024];
  int          addr_log [$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (sram_ren) sram_rdata <= mem[sram_raddr];
    if (rst_n && sram_ren) addr_log.push_back(int'(sram_raddr));
  end

  task automatic chk_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int lane_of(input logic [VW-1:0] v, input int i);
    logic [OW-1:0] l;
    l = v[i*OW +: OW];
    return int'($signed(l));
  endfunction

  // Vector v of a transaction at base b, straight from the packing rule.
  function automatic logic [VW-1:0] exp_vec(input int b, input int v);
    logic [VW-1:0] r;
    logic [31:0]   w;
    logic [15:0]   h;
    int            x;
    r = '0;
    for (int i = 0; i < NL; i++) begin
      w = mem[(b + 16 * v + i / 2) % 1024];
      h = (i % 2 == 1) ? w[31:16] : w[15:0];
      x = int'($signed(h));
      r[i*OW +: OW] = x[OW-1:0];
    end
    return r;
  endfunction

  // Reference model: phase plus offset since the vector's launch edge.
  int m_phase = P_IDLE;
  int m_off = 0;
  int m_vec = 0;
  int m_base = 0;
  int m_n = 0;
  int m_addr = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = P_IDLE;
      m_addr  = 0;
      m_off   = 0;
    end else begin
      case (m_phase)
        P_IDLE: if (start) begin
          m_base = int'(base_addr);
          m_n    = int'(num_vec);
          m_vec  = 0;
          m_off  = 0;
          if (m_n == 0) m_phase = P_FINW;
          else begin
            m_phase = P_LOAD;
            m_addr  = m_base;
          end
        end
        P_LOAD: begin
          m_off++;
          if (m_off <= 15) m_addr = (m_base + 16 * m_vec + m_off) % 1024;
          if (m_off == 17) m_phase = P_HOLD;
        end
        P_HOLD: if (vec_ready) begin
          if (m_vec == m_n - 1) m_phase = P_FINW;
          else begin
            m_vec++;
            m_off   = 0;
            m_addr  = (m_base + 16 * m_vec) % 1024;
            m_phase = P_LOAD;
          end
        end
        P_FINW: m_phase = P_DONE;
        default: m_phase = P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    chk_int("busy", int'(busy), int'(m_phase != P_IDLE));
    chk_int("done", int'(done), int'(m_phase == P_DONE));
    chk_int("vec_valid", int'(vec_valid), int'(m_phase == P_HOLD));
    chk_int("sram_ren", int'(sram_ren), int'(m_phase == P_LOAD && m_off <= 15));
    chk_int("sram_raddr", int'(sram_raddr), m_addr);
    if (m_phase == P_HOLD) chk_vec("vec_data", vec_data, exp_vec(m_base, m_vec));
  end

  task automatic run_txn(
    input  logic [9:0]    b,
    input  logic [7:0]    n,
    input  int            rmode,
    output int            t_start,
    output int            t_valid,
    output int            t_hs,
    output int            t_done,
    output int            n_hs,
    output int            busy_cyc,
    output int            ren_in_hold,
    output logic [VW-1:0] first_vec
  );
    int vcnt;
    bit seen, fin;
    vcnt = 0; seen = 0; fin = 0;
    t_valid = -1; t_hs = -1; t_done = -1; n_hs = 0; busy_cyc = 0; ren_in_hold = 0;
    first_vec = '0;
    @(negedge clk);
    start = 1'b1; base_addr = b; num_vec = n;
    vec_ready = (rmode == 0);
    t_start = cyc + 1;
    for (int k = 0; k < 3000 && !fin; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cyc++;
      if (vec_valid && !seen) begin
        t_valid = cyc; first_vec = vec_data; seen = 1;
      end
      if (vec_valid) begin
        vcnt++;
        if (sram_ren) ren_in_hold++;
      end
      case (rmode)
        0: vec_ready = 1'b1;
        1: vec_ready = 1'($urandom_range(0, 1));
        default: vec_ready = (vcnt >= 11);
      endcase
      if (rmode == 2 && vcnt == 3) begin
        start = 1'b1; base_addr = 10'd5; num_vec = 8'd2;
      end
      if (vec_valid && vec_ready) begin
        t_hs = cyc + 1; n_hs++; vcnt = 0;
      end
      if (done) begin
        t_done = cyc; fin = 1;
      end
    end
    chk_int("txn_completed", int'(fin), 1);
    vec_ready = 1'b0;
  endtask

  int ts, tv, th, td, nh, bc, rh;
  logic [VW-1:0] fv;

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = $urandom;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk_vec("reset_vec_data", vec_data, '0);
    chk_int("reset_busy", int'(busy), 0);

    // Reset during FETCH at word 5.
    @(negedge clk);
    start = 1'b1; base_addr = 10'd0; num_vec = 8'd2; vec_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 40 && !(sram_ren && sram_raddr == 10'd5); k++) @(negedge clk);
    chk_int("t1_reached_word5", int'(sram_raddr), 5);
    #2 rst_n = 1'b0;
    #1;
    chk_int("t1_ren", int'(sram_ren), 0);
    chk_int("t1_valid", int'(vec_valid), 0);
    chk_int("t1_busy", int'(busy), 0);
    chk_vec("t1_vec_zero", vec_data, '0);
    vec_ready = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_int("t1_no_done", int'(done), 0);
    end

    // Lane i = i, base 0, one vector.
    for (int k = 0; k < 16; k++) mem[k] = {16'(2 * k + 1), 16'(2 * k)};
    addr_log.delete();
    run_txn(10'd0, 8'd1, 0, ts, tv, th, td, nh, bc, rh, fv);
    chk_int("t2_latency", tv - ts, 17);
    chk_int("t2_done_after_hs", td - th, 1);
    chk_int("t2_nreads", addr_log.size(), 16);
    for (int k = 0; k < 16 && k < addr_log.size(); k++) chk_int("t2_addr", addr_log[k], k);
    for (int i = 0; i < NL; i++) chk_int("t2_lane", lane_of(fv, i), i);

    // Saturation extremes.
    mem[100] = {16'h7FFF, 16'h8000};
    mem[101] = {16'h0001, 16'hFFFF};
    run_txn(10'd100, 8'd1, 0, ts, tv, th, td, nh, bc, rh, fv);
    chk_int("t3_lane0", lane_of(fv, 0), -32768);
    chk_int("t3_lane1", lane_of(fv, 1), 32767);
    chk_int("t3_lane2", lane_of(fv, 2), -1);
    chk_int("t3_lane3", lane_of(fv, 3), 1);

    // Address wrap, three vectors.
    addr_log.delete();
    run_txn(10'd1010, 8'd3, 0, ts, tv, th, td, nh, bc, rh, fv);
    chk_int("t4_handshakes", nh, 3);
    chk_int("t4_nreads", addr_log.size(), 48);
    if (addr_log.size() == 48) begin
      chk_int("t4_first", addr_log[0], 1010);
      chk_int("t4_top", addr_log[13], 1023);
      chk_int("t4_wrap", addr_log[14], 0);
      chk_int("t4_vec2", addr_log[16], 2);
      chk_int("t4_vec3", addr_log[32], 18);
    end

    // Backpressure for 10 cycles with a start pulse in HOLD.
    addr_log.delete();
    run_txn(10'd200, 8'd1, 2, ts, tv, th, td, nh, bc, rh, fv);
    chk_int("t5_hold_len", th - tv, 11);
    chk_int("t5_ren_in_hold", rh, 0);
    chk_int("t5_handshakes", nh, 1);
    repeat (4) @(negedge clk);
    chk_int("t5_start_ignored", addr_log.size(), 16);

    // Zero vectors.
    addr_log.delete();
    run_txn(10'd7, 8'd0, 0, ts, tv, th, td, nh, bc, rh, fv);
    chk_int("t6_done_edge", td - ts, 1);
    chk_int("t6_busy_cycles", bc, 2);
    chk_int("t6_no_reads", addr_log.size(), 0);
    @(negedge clk);
    chk_int("t6_busy_low", int'(busy), 0);

    // Randomised transactions.
    for (int t = 0; t < 12; t++) begin
      logic [9:0] rb;
      logic [7:0] rn;
      for (int a = 0; a < 1024; a++) mem[a] = $urandom;
      rb = 10'($urandom_range(0, 1023));
      rn = 8'($urandom_range(0, 4));
      run_txn(rb, rn, int'($urandom_range(0, 1)), ts, tv, th, td, nh, bc, rh, fv);
      chk_int("rand_handshakes", nh, int'(rn));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
